// File: rtl/decode_pkg.sv
// Purpose: shared RV32I decode types, opcode constants and bundle layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package decode_pkg;

    // Widths used by the decoded bundle carried between pipeline stages
    localparam int DEC_XLEN = 32;
    localparam int DEC_PC_W = 32;

    // Base-ISA major opcodes (instr[6:0])
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [2:0] {
        FMT_R    = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_NONE = 3'd6
    } fmt_e;

    typedef struct packed {
        logic [DEC_PC_W-1:0] pc;
        logic [6:0]          op;
        logic [4:0]          rd;
        logic [4:0]          rs1;
        logic [4:0]          rs2;
        logic [2:0]          funct3;
        logic [6:0]          funct7;
        logic [DEC_XLEN-1:0] imm;
        fmt_e                fmt;
        logic                illegal;
    } dec_bundle_t;

endpackage

// File: rtl/decode_if.sv
// Purpose: fetch-side and execute-side handshake/bus signals of the decode stage.
// Latency: n/a (wiring only).
// Backpressure: in_ready/out_ready valid-ready pairs; slave modport is the decode stage.
interface decode_if
    import decode_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int PC_W = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [PC_W-1:0] in_pc;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [PC_W-1:0] out_pc;
    logic [6:0]      out_op;
    logic [4:0]      out_rd;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [2:0]      out_funct3;
    logic [6:0]      out_funct7;
    logic [XLEN-1:0] out_imm;
    fmt_e            out_fmt;
    logic            out_illegal;
    logic [31:0]     dec_count;

    // Environment view: drives fetch inputs, flush and execute ready
    modport master (
        output in_valid, in_instr, in_pc, flush, out_ready,
        input  in_ready, out_valid, out_pc, out_op, out_rd, out_rs1, out_rs2,
               out_funct3, out_funct7, out_imm, out_fmt, out_illegal, dec_count
    );

    // Decode stage view
    modport slave (
        input  in_valid, in_instr, in_pc, flush, out_ready,
        output in_ready, out_valid, out_pc, out_op, out_rd, out_rs1, out_rs2,
               out_funct3, out_funct7, out_imm, out_fmt, out_illegal, dec_count
    );
endinterface

// File: rtl/decode_comb.sv
// Purpose: combinational RV32I field/immediate/format decode of one instruction word.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; the caller owns all handshaking.
module decode_comb
    import decode_pkg::*;
(
    input  logic [31:0]         instr,
    input  logic [DEC_PC_W-1:0] pc,
    output dec_bundle_t         dec
);

    fmt_e fmt;

    // Classify the opcode; anything unlisted (including instr[1:0] != 11) is FMT_NONE
    always_comb begin
        fmt = FMT_NONE;
        case (instr[6:0])
            OP_REG:                               fmt = FMT_R;
            OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM:  fmt = FMT_I;
            OP_STORE:                             fmt = FMT_S;
            OP_BRANCH:                            fmt = FMT_B;
            OP_LUI, OP_AUIPC:                     fmt = FMT_U;
            OP_JAL:                               fmt = FMT_J;
            default:                              fmt = FMT_NONE;
        endcase
    end

    // Populate only the fields each format defines; the rest stay zero
    always_comb begin
        dec         = '0;
        dec.pc      = pc;
        dec.op      = instr[6:0];
        dec.fmt     = fmt;
        dec.illegal = (fmt == FMT_NONE);
        case (fmt)
            FMT_R: begin
                dec.rd     = instr[11:7];
                dec.rs1    = instr[19:15];
                dec.rs2    = instr[24:20];
                dec.funct3 = instr[14:12];
                dec.funct7 = instr[31:25];
            end
            FMT_I: begin
                dec.rd     = instr[11:7];
                dec.rs1    = instr[19:15];
                dec.funct3 = instr[14:12];
                dec.imm    = DEC_XLEN'($signed(instr[31:20]));
            end
            FMT_S: begin
                dec.rs1    = instr[19:15];
                dec.rs2    = instr[24:20];
                dec.funct3 = instr[14:12];
                dec.imm    = DEC_XLEN'($signed({instr[31:25], instr[11:7]}));
            end
            FMT_B: begin
                dec.rs1    = instr[19:15];
                dec.rs2    = instr[24:20];
                dec.funct3 = instr[14:12];
                dec.imm    = DEC_XLEN'($signed({instr[31], instr[7], instr[30:25],
                                                instr[11:8], 1'b0}));
            end
            FMT_U: begin
                dec.rd     = instr[11:7];
                dec.imm    = DEC_XLEN'($signed({instr[31:12], 12'b0}));
            end
            FMT_J: begin
                dec.rd     = instr[11:7];
                dec.imm    = DEC_XLEN'($signed({instr[31], instr[19:12], instr[20],
                                                instr[30:21], 1'b0}));
            end
            default: begin
                dec.illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// Purpose: registered RV32I decode stage between fetch and execute, with decoded-bundle counter.
// Latency: 1 cycle from input accept to out_valid; 1 instr/cycle while out_ready is high.
// Backpressure: one-entry skid buffer; in_ready = !skid valid, never combinational on out_ready.
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int PC_W = 32
) (
    input logic     clk,
    input logic     rst_n,
    decode_if.slave bus
);

    dec_bundle_t in_dec;
    dec_bundle_t or_q, or_d;
    dec_bundle_t sr_q, sr_d;
    logic        or_vld_q, or_vld_d;
    logic        sr_vld_q, sr_vld_d;
    logic [31:0] cnt_q, cnt_d;
    logic        accept;
    logic        consume;

    decode_comb u_comb (
        .instr (bus.in_instr),
        .pc    (DEC_PC_W'(bus.in_pc)),
        .dec   (in_dec)
    );

    // Flush blocks acceptance; readiness only looks at the skid slot
    assign bus.in_ready = !sr_vld_q;
    assign accept       = bus.in_valid && !sr_vld_q && !bus.flush;
    assign consume      = or_vld_q && bus.out_ready;

    // Next-state for output/skid registers and handshake counter
    always_comb begin
        or_d     = or_q;
        sr_d     = sr_q;
        or_vld_d = or_vld_q;
        sr_vld_d = sr_vld_q;
        cnt_d    = cnt_q;

        // A handshake in a flush cycle still completed, so it is counted
        if (consume) begin
            cnt_d = cnt_q + 32'd1;
        end

        if (bus.flush) begin
            or_vld_d = 1'b0;
            sr_vld_d = 1'b0;
        end else begin
            if (consume) begin
                if (sr_vld_q) begin
                    or_d     = sr_q;
                    or_vld_d = 1'b1;
                    sr_vld_d = 1'b0;
                end else begin
                    or_vld_d = 1'b0;
                end
            end
            // accept implies the skid slot was empty, so it never races the SR->OR move
            if (accept) begin
                if (!or_vld_q || consume) begin
                    or_d     = in_dec;
                    or_vld_d = 1'b1;
                end else begin
                    sr_d     = in_dec;
                    sr_vld_d = 1'b1;
                end
            end
        end
    end

    // State registers, cleared immediately by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            or_q     <= '0;
            sr_q     <= '0;
            or_vld_q <= 1'b0;
            sr_vld_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            or_q     <= or_d;
            sr_q     <= sr_d;
            or_vld_q <= or_vld_d;
            sr_vld_q <= sr_vld_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.out_valid   = or_vld_q;
    assign bus.out_pc      = PC_W'(or_q.pc);
    assign bus.out_op      = or_q.op;
    assign bus.out_rd      = or_q.rd;
    assign bus.out_rs1     = or_q.rs1;
    assign bus.out_rs2     = or_q.rs2;
    assign bus.out_funct3  = or_q.funct3;
    assign bus.out_funct7  = or_q.funct7;
    assign bus.out_imm     = XLEN'($signed(or_q.imm));
    assign bus.out_fmt     = or_q.fmt;
    assign bus.out_illegal = or_q.illegal;
    assign bus.dec_count   = cnt_q;

endmodule
